// File: rtl/tcb_pkg.sv
// Shared constants and the response-slot type used by the TCB memory arbiter.
package tcb_pkg;

    localparam int PN_MAX  = 8;
    localparam int DLY_MIN = 1;
    localparam int DLY_MAX = 4;
    localparam int DAT_MAX = 64;
    localparam int PRT_W   = $clog2(PN_MAX);

    // One in-flight response; rdt is sized for the widest data bus.
    typedef struct packed {
        logic               vld;
        logic [PRT_W-1:0]   prt;
        logic               rd;
        logic               sts;
        logic [DAT_MAX-1:0] rdt;
    } rsp_slot_t;

endpackage

// File: rtl/tcb_lib_arb_rr.sv
// Round-robin arbiter: one-hot grant among requesters, searching from the port after the last grant.
module tcb_lib_arb_rr #(
    parameter int PN = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [PN-1:0] req,
    output logic [PN-1:0] gnt
);

    localparam int PW = (PN > 1) ? $clog2(PN) : 1;

    logic [PW-1:0] ptr_q, ptr_d;
    logic [PN-1:0] mask;
    logic [PN-1:0] req_hi;
    logic [PN-1:0] pick;

    // Ports above the last grant win first; otherwise wrap to the lowest requester.
    always_comb begin
        mask = '0;
        for (int j = 0; j < PN; j++) begin
            mask[j] = (PW'(j) > ptr_q);
        end
        req_hi = req & mask;
        pick   = (req_hi != '0) ? req_hi : req;
        gnt    = pick & (~pick + PN'(1));
        ptr_d  = ptr_q;
        for (int j = 0; j < PN; j++) begin
            if (gnt[j]) begin
                ptr_d = PW'(j);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q <= PW'(PN - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/tcb_mem_arb.sv
// Multi-port TCB memory: round-robin arbitration into a byte-writable single-port RAM,
// with responses returned to the granted port a fixed number of cycles later.
module tcb_mem_arb #(
    parameter int PN  = 2,
    parameter int ADR = 32,
    parameter int DAT = 32,
    parameter int SIZ = 4096,
    parameter int DLY = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [PN-1:0]       tcb_vld,
    output logic [PN-1:0]       tcb_rdy,
    input  logic [PN-1:0]       tcb_wen,
    input  logic [PN*ADR-1:0]   tcb_adr,
    input  logic [PN*DAT/8-1:0] tcb_ben,
    input  logic [PN*DAT-1:0]   tcb_wdt,
    output logic [PN*DAT-1:0]   tcb_rdt,
    output logic [PN-1:0]       tcb_sts,
    output logic [PN-1:0]       tcb_rsp
);

    import tcb_pkg::*;

    localparam int BW    = DAT / 8;
    localparam int OB    = $clog2(BW);
    localparam int WORDS = SIZ / BW;
    localparam int AW    = $clog2(WORDS);
    localparam int DLY_C = (DLY < DLY_MIN) ? DLY_MIN : ((DLY > DLY_MAX) ? DLY_MAX : DLY);

    logic [PN-1:0] req;
    logic [PN-1:0] gnt;

    // A request is a transfer exactly when its grant is high; nothing is granted in reset.
    assign req     = tcb_vld & {PN{rst}};
    assign tcb_rdy = gnt;

    tcb_lib_arb_rr #(.PN(PN)) u_arb (
        .clk (clk),
        .rst (rst),
        .req (req),
        .gnt (gnt)
    );

    logic             sel_vld;
    logic             sel_wen;
    logic [ADR-1:0]   sel_adr;
    logic [BW-1:0]    sel_ben;
    logic [DAT-1:0]   sel_wdt;
    logic [PRT_W-1:0] sel_prt;
    logic             sel_oor;
    logic [AW-1:0]    sel_idx;

    always_comb begin
        sel_vld = |gnt;
        sel_wen = 1'b0;
        sel_adr = '0;
        sel_ben = '0;
        sel_wdt = '0;
        sel_prt = '0;
        for (int j = 0; j < PN; j++) begin
            if (gnt[j]) begin
                sel_wen = tcb_wen[j];
                sel_adr = tcb_adr[j*ADR +: ADR];
                sel_ben = tcb_ben[j*BW +: BW];
                sel_wdt = tcb_wdt[j*DAT +: DAT];
                sel_prt = PRT_W'(j);
            end
        end
        sel_oor = (sel_adr >= ADR'(SIZ));
        sel_idx = sel_adr[OB +: AW];
    end

    logic [DAT-1:0] mem [WORDS];
    logic [DAT-1:0] rdat_q;
    logic           mem_we;

    assign mem_we = sel_vld && sel_wen && !sel_oor;

    // Array contents survive reset, so this block has no reset branch.
    always_ff @(posedge clk) begin
        for (int b = 0; b < BW; b++) begin
            if (mem_we && sel_ben[b]) begin
                mem[sel_idx][b*8 +: 8] <= sel_wdt[b*8 +: 8];
            end
        end
        if (sel_vld && !sel_wen) begin
            rdat_q <= mem[sel_idx];
        end
    end

    rsp_slot_t stg_q [DLY_C];
    rsp_slot_t stg_d [DLY_C];
    rsp_slot_t slot_res;
    rsp_slot_t out_slot;

    always_comb begin
        stg_d[0]     = '0;
        stg_d[0].vld = sel_vld;
        stg_d[0].prt = sel_prt;
        stg_d[0].rd  = sel_vld && !sel_wen;
        stg_d[0].sts = sel_vld && sel_oor;
        // RAM data lands alongside stage 0; merge it before it moves down the pipe.
        slot_res = stg_q[0];
        if (stg_q[0].rd && !stg_q[0].sts) begin
            slot_res.rdt = DAT_MAX'(rdat_q);
        end
        for (int k = 1; k < DLY_C; k++) begin
            stg_d[k] = (k == 1) ? slot_res : stg_q[k-1];
        end
        out_slot = (DLY_C == 1) ? slot_res : stg_q[DLY_C-1];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < DLY_C; k++) begin
                stg_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < DLY_C; k++) begin
                stg_q[k] <= stg_d[k];
            end
        end
    end

    always_comb begin
        tcb_rsp = '0;
        tcb_sts = '0;
        tcb_rdt = '0;
        for (int j = 0; j < PN; j++) begin
            if (out_slot.vld && (out_slot.prt == PRT_W'(j))) begin
                tcb_rsp[j]             = 1'b1;
                tcb_sts[j]             = out_slot.sts;
                tcb_rdt[j*DAT +: DAT]  = out_slot.rdt[DAT-1:0];
            end
        end
    end

    logic unused_slot;
    assign unused_slot = ^{out_slot.rd, out_slot.rdt};

endmodule

// File: tb/tb_tcb_mem_arb.sv
// Bench for tcb_mem_arb: three instances (DLY 1/2/3) share one stimulus stream and are
// checked every cycle against a transfer-history model of arbitration and memory.
module tb_tcb_mem_arb;

    localparam int PN  = 2;
    localparam int ADR = 32;
    localparam int DAT = 32;
    localparam int SIZ = 4096;
    localparam int BW  = DAT / 8;
    localparam int HN  = 2048;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic [PN-1:0]     vld;
    logic [PN-1:0]     wen;
    logic [PN*ADR-1:0] adr;
    logic [PN*BW-1:0]  ben;
    logic [PN*DAT-1:0] wdt;

    logic [PN-1:0]     rdy_1, rsp_1, sts_1;
    logic [PN-1:0]     rdy_2, rsp_2, sts_2;
    logic [PN-1:0]     rdy_3, rsp_3, sts_3;
    logic [PN*DAT-1:0] rdt_1, rdt_2, rdt_3;

    tcb_mem_arb #(.PN(PN), .ADR(ADR), .DAT(DAT), .SIZ(SIZ), .DLY(1)) u_dly1 (
        .clk(clk), .rst(rst), .tcb_vld(vld), .tcb_rdy(rdy_1), .tcb_wen(wen), .tcb_adr(adr),
        .tcb_ben(ben), .tcb_wdt(wdt), .tcb_rdt(rdt_1), .tcb_sts(sts_1), .tcb_rsp(rsp_1)
    );

    tcb_mem_arb #(.PN(PN), .ADR(ADR), .DAT(DAT), .SIZ(SIZ), .DLY(2)) u_dly2 (
        .clk(clk), .rst(rst), .tcb_vld(vld), .tcb_rdy(rdy_2), .tcb_wen(wen), .tcb_adr(adr),
        .tcb_ben(ben), .tcb_wdt(wdt), .tcb_rdt(rdt_2), .tcb_sts(sts_2), .tcb_rsp(rsp_2)
    );

    tcb_mem_arb #(.PN(PN), .ADR(ADR), .DAT(DAT), .SIZ(SIZ), .DLY(3)) u_dly3 (
        .clk(clk), .rst(rst), .tcb_vld(vld), .tcb_rdy(rdy_3), .tcb_wen(wen), .tcb_adr(adr),
        .tcb_ben(ben), .tcb_wdt(wdt), .tcb_rdt(rdt_3), .tcb_sts(sts_3), .tcb_rsp(rsp_3)
    );

    always #5 clk = ~clk;

    // Reference model: byte-addressed memory image plus a per-cycle log of transfers.
    logic [DAT-1:0] mem_m [SIZ/BW];
    int             last_g;
    int             cyc;
    int             rst_cyc;
    bit             hist_v [HN];
    int             hist_p [HN];
    logic           hist_s [HN];
    logic [DAT-1:0] hist_d [HN];
    int             checks;
    int             errors;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic int grant_of(input logic [PN-1:0] v);
        int g;
        g = -1;
        for (int k = 1; k <= PN; k++) begin
            int p;
            p = (last_g + k) % PN;
            if (g < 0 && v[p]) g = p;
        end
        return g;
    endfunction

    task automatic chk_inst(input string nm, input int d, input logic [PN-1:0] rdy_o,
                            input logic [PN-1:0] rsp_o, input logic [PN-1:0] sts_o,
                            input logic [PN*DAT-1:0] rdt_o, input int g);
        logic [PN-1:0]     e_rdy;
        logic [PN-1:0]     e_rsp;
        logic [PN-1:0]     e_sts;
        logic [PN*DAT-1:0] e_rdt;
        int                t;
        e_rdy = '0;
        e_rsp = '0;
        e_sts = '0;
        e_rdt = '0;
        t     = cyc - d;
        if (g >= 0) e_rdy[g] = 1'b1;
        if (t >= rst_cyc && t >= 0 && hist_v[t]) begin
            e_rsp[hist_p[t]]             = 1'b1;
            e_sts[hist_p[t]]             = hist_s[t];
            e_rdt[hist_p[t]*DAT +: DAT]  = hist_d[t];
        end
        chk({nm, "_rdy"}, 64'(rdy_o), 64'(e_rdy));
        chk({nm, "_rsp"}, 64'(rsp_o), 64'(e_rsp));
        chk({nm, "_sts"}, 64'(sts_o), 64'(e_sts));
        chk({nm, "_rdt"}, 64'(rdt_o), 64'(e_rdt));
    endtask

    // Inputs are driven just after a falling edge; check, then let the rising edge transfer.
    task automatic cycle();
        int             g;
        int             w;
        logic [ADR-1:0] a;
        logic           oor;
        #1;
        g = rst ? grant_of(vld) : -1;
        chk_inst("d1", 1, rdy_1, rsp_1, sts_1, rdt_1, g);
        chk_inst("d2", 2, rdy_2, rsp_2, sts_2, rdt_2, g);
        chk_inst("d3", 3, rdy_3, rsp_3, sts_3, rdt_3, g);
        hist_v[cyc] = 1'b0;
        if (g >= 0) begin
            a   = adr[g*ADR +: ADR];
            oor = (a >= 32'(SIZ));
            w   = int'(a[11:2]);
            hist_v[cyc] = 1'b1;
            hist_p[cyc] = g;
            hist_s[cyc] = oor;
            hist_d[cyc] = '0;
            if (wen[g]) begin
                if (!oor) begin
                    for (int b = 0; b < BW; b++) begin
                        if (ben[g*BW + b]) mem_m[w][8*b +: 8] = wdt[g*DAT + 8*b +: 8];
                    end
                end
            end else if (!oor) begin
                hist_d[cyc] = mem_m[w];
            end
            last_g = g;
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic idle();
        vld = '0;
        wen = '0;
        adr = '0;
        ben = '0;
        wdt = '0;
    endtask

    task automatic set_port(input int p, input logic v, input logic w, input logic [ADR-1:0] a,
                            input logic [BW-1:0] b, input logic [DAT-1:0] d);
        vld[p]              = v;
        wen[p]              = w;
        adr[p*ADR +: ADR]   = a;
        ben[p*BW +: BW]     = b;
        wdt[p*DAT +: DAT]   = d;
    endtask

    task automatic do_reset(input int n);
        rst     = 1'b0;
        idle();
        rst_cyc = cyc;
        last_g  = PN - 1;
        repeat (n) cycle();
        rst = 1'b1;
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        cyc     = 0;
        rst_cyc = 0;
        last_g  = PN - 1;
        idle();
        @(negedge clk);
        do_reset(3);

        // Port 0 writes, then port 1 reads the same word back one cycle later.
        idle(); set_port(0, 1'b1, 1'b1, 32'h0, 4'hF, 32'h01234567); cycle();
        idle(); set_port(1, 1'b1, 1'b0, 32'h0, 4'h0, 32'h0); cycle();
        chk("r35_rsp", 64'(rsp_1), 64'(2'b10));
        chk("r35_rdt", 64'(rdt_1[63:32]), 64'(32'h01234567));
        chk("r35_sts", 64'(sts_1), 64'(2'b00));
        idle(); repeat (3) cycle();

        for (int w = 1; w < 16; w++) begin
            idle();
            set_port(w % 2, 1'b1, 1'b1, 32'(w * 4), 4'hF, (w == 4) ? 32'h0 : 32'($urandom()));
            cycle();
        end

        // Partial byte write over zeros.
        idle(); set_port(0, 1'b1, 1'b1, 32'h10, 4'b0101, 32'hAABBCCDD); cycle();
        idle(); set_port(0, 1'b1, 1'b0, 32'h12, 4'h0, 32'h0); cycle();
        chk("r37_rdt", 64'(rdt_1[31:0]), 64'(32'h00BB00DD));

        // Out-of-range read and write; word 0 must keep its data.
        idle(); set_port(1, 1'b1, 1'b0, 32'h1000, 4'h0, 32'h0); cycle();
        chk("r38_sts", 64'(sts_1), 64'(2'b10));
        chk("r38_rdt", 64'(rdt_1), 64'(0));
        idle(); set_port(1, 1'b1, 1'b1, 32'h1000, 4'hF, 32'hDEADBEEF); cycle();
        chk("r38_wsts", 64'(sts_1), 64'(2'b10));
        idle(); set_port(0, 1'b1, 1'b0, 32'h0, 4'h0, 32'h0); cycle();
        chk("r38_keep", 64'(rdt_1[31:0]), 64'(32'h01234567));

        // Back-to-back reads seen by the DLY=3 instance three cycles later.
        idle(); set_port(0, 1'b1, 1'b0, 32'h00, 4'h0, 32'h0); cycle();
        set_port(0, 1'b1, 1'b0, 32'h10, 4'h0, 32'h0); cycle();
        set_port(0, 1'b1, 1'b0, 32'h20, 4'h0, 32'h0); cycle();
        idle();
        chk("r39_a_rsp", 64'(rsp_3), 64'(2'b01));
        chk("r39_a_rdt", 64'(rdt_3[31:0]), 64'(32'h01234567));
        cycle();
        chk("r39_b_rdt", 64'(rdt_3[31:0]), 64'(32'h00BB00DD));
        cycle();
        chk("r39_c_rdt", 64'(rdt_3[31:0]), 64'(mem_m[8]));
        cycle();

        // Reset one cycle after a read: the response is dropped, memory is kept.
        idle(); set_port(0, 1'b1, 1'b0, 32'h10, 4'h0, 32'h0); cycle();
        rst     = 1'b0;
        idle();
        rst_cyc = cyc;
        last_g  = PN - 1;
        #1;
        chk("r40_rsp2", 64'(rsp_2), 64'(0));
        chk("r40_rdt2", 64'(rdt_2), 64'(0));
        repeat (2) cycle();
        rst = 1'b1;

        // Both ports requesting continuously straight after reset.
        for (int i = 0; i < 4; i++) begin
            set_port(0, 1'b1, 1'b0, 32'h00, 4'h0, 32'h0);
            set_port(1, 1'b1, 1'b0, 32'h10, 4'h0, 32'h0);
            #1;
            chk("r36_rdy", 64'(rdy_1), 64'((i % 2 == 0) ? 2'b01 : 2'b10));
            cycle();
        end
        idle();
        chk("r36_last", 64'(rdt_1[63:32]), 64'(32'h00BB00DD));
        repeat (3) cycle();

        for (int i = 0; i < 300; i++) begin
            if (i == 150) do_reset(2);
            for (int p = 0; p < PN; p++) begin
                logic [ADR-1:0] a;
                if ($urandom_range(0, 9) == 0) begin
                    a = ($urandom_range(0, 1) == 0) ? (32'h1000 + 32'($urandom_range(0, 4095))) : 32'hFFFF_FFFC;
                end else begin
                    a = 32'($urandom_range(0, 63));
                end
                set_port(p, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), a,
                         4'($urandom_range(0, 15)), 32'($urandom()));
            end
            cycle();
        end
        idle();
        repeat (5) cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
